// File: rtl/aes_pkg.sv
// aes_pkg: GF(2^8) constant multipliers, FSM states and column slice helpers for MixColumns
package aes_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return c == 8'h01 ? b :
           c == 8'h02 ? x2 :
           c == 8'h03 ? x2 ^ b :
           c == 8'h09 ? x8 ^ b :
           c == 8'h0B ? x8 ^ x2 ^ b :
           c == 8'h0D ? x8 ^ x4 ^ b :
           c == 8'h0E ? x8 ^ x4 ^ x2 : 8'h00;
  endfunction
  // column i lives at bit offset (3-i)*32, i.e. {~i, 5'd0}
  function automatic logic [31:0] col_get(input logic [127:0] s, input logic [1:0] i);
    return s[{~i, 5'd0} +: 32];
  endfunction
  function automatic logic [127:0] col_set(input logic [127:0] s, input logic [1:0] i, input logic [31:0] v);
    logic [127:0] r;
    r = s;
    r[{~i, 5'd0} +: 32] = v;
    return r;
  endfunction
endpackage

// File: rtl/mix_column_word.sv
// mix_column_word: combinational forward/inverse MixColumns of one 32-bit column
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);
  logic [31:0] w_k;
  logic [7:0]  w_a [4];
  assign w_k = inv ? 32'h0E0B0D09 : 32'h02030101;
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_a[r] = col_in[31-8*r -: 8];
    assign col_out[31-8*r -: 8] = gf_mul_const(w_a[r], w_k[31:24]) ^
                                  gf_mul_const(w_a[(r+1)%4], w_k[23:16]) ^
                                  gf_mul_const(w_a[(r+2)%4], w_k[15:8]) ^
                                  gf_mul_const(w_a[(r+3)%4], w_k[7:0]);
  end
endmodule

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per cycle
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv_mode,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int NUM_ITER = 4 / COLS_PER_CYCLE;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  state_t       r_st, w_st_nxt;
  logic [127:0] r_state, r_dout, w_next;
  logic [1:0]   r_idx;
  logic         r_inv, w_last;
  logic [31:0]  w_col [COLS_PER_CYCLE];
  assign w_last    = r_idx == 2'((NUM_ITER - 1) * COLS_PER_CYCLE);
  assign in_ready  = r_st == IDLE;
  assign out_valid = r_st == DONE;
  assign busy      = r_st != IDLE;
  assign data_out  = r_dout;
  for (genvar c = 0; c < COLS_PER_CYCLE; c++) begin : g_col
    mix_column_word u_mc (
      .col_in (col_get(r_state, r_idx + 2'(c))),
      .inv    (r_inv),
      .col_out(w_col[c])
    );
  end
  always_comb begin
    w_next = r_state;
    for (int k = 0; k < COLS_PER_CYCLE; k++) w_next = col_set(w_next, r_idx + 2'(k), w_col[k]);
  end
  always_comb begin
    w_st_nxt = flush                          ? IDLE :
               (r_st == IDLE && in_valid)     ? BUSY :
               (r_st == BUSY && w_last)       ? DONE :
               (r_st == DONE && out_ready)    ? IDLE : r_st;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= IDLE;
    else        r_st <= w_st_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_dout  <= '0;
      r_idx   <= '0;
      r_inv   <= 1'b0;
    end else if (flush) begin
      r_idx <= '0;
    end else if (r_st == IDLE && in_valid) begin
      r_state <= data_in;
      r_inv   <= inv_mode;
      r_idx   <= '0;
    end else if (r_st == BUSY) begin
      r_state <= w_next;
      r_idx   <= r_idx + 2'(COLS_PER_CYCLE);
      if (w_last) r_dout <= w_next;
    end
  end
endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: directed vectors for widths 1/2/4 plus backpressure, flush and async reset sequences
module tb_mix_columns_iter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush_a     [3];
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic         inv_a       [3];
  logic [127:0] data_in_a   [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic [127:0] data_out_a  [3];
  logic         busy_a      [3];
  int n_vec = 0;
  int n_bad = 0;
  localparam logic [127:0] A_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] A_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] B_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] B_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  always #5 clk = ~clk;
  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .flush(flush_a[0]), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .inv_mode(inv_a[0]), .data_in(data_in_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .data_out(data_out_a[0]), .busy(busy_a[0]));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .flush(flush_a[1]), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .inv_mode(inv_a[1]), .data_in(data_in_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .data_out(data_out_a[1]), .busy(busy_a[1]));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .flush(flush_a[2]), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .inv_mode(inv_a[2]), .data_in(data_in_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .data_out(data_out_a[2]), .busy(busy_a[2]));
  typedef struct {
    int           k;
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
    int           lat;
  } vec_t;
  vec_t tv [8];
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] flags(input int k);
    return 128'({busy_a[k], in_ready_a[k], out_valid_a[k]});
  endfunction
  task automatic wait_out(input int k, output int n);
    n = 0;
    while (!out_valid_a[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic run_vec(input int k, input logic inv, input logic [127:0] din, input logic [127:0] exp,
                         input int lat, input string nm);
    int n;
    in_valid_a[k] = 1'b1;
    inv_a[k] = inv;
    data_in_a[k] = din;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    inv_a[k] = ~inv;
    data_in_a[k] = '0;
    wait_out(k, n);
    check({nm, " latency"}, 128'(n), 128'(lat));
    check({nm, " data"}, data_out_a[k], exp);
    out_ready_a[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[k] = 1'b0;
    check({nm, " back to idle"}, flags(k), 128'b010);
  endtask
  initial begin
    int n;
    logic seen;
    for (int k = 0; k < 3; k++) begin
      flush_a[k] = 1'b0; in_valid_a[k] = 1'b0; inv_a[k] = 1'b0; data_in_a[k] = '0; out_ready_a[k] = 1'b0;
    end
    tv[0] = '{0, 1'b0, A_IN, A_OUT, 4};
    tv[1] = '{2, 1'b1, A_OUT, A_IN, 1};
    tv[2] = '{1, 1'b0, B_IN, B_OUT, 2};
    tv[3] = '{1, 1'b1, B_OUT, B_IN, 2};
    tv[4] = '{0, 1'b1, A_OUT, A_IN, 4};
    tv[5] = '{2, 1'b0, A_IN, A_OUT, 1};
    tv[6] = '{1, 1'b0, A_IN, A_OUT, 2};
    tv[7] = '{2, 1'b1, B_OUT, B_IN, 1};
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset flags c%0d", k), flags(k), 128'b010);
      check($sformatf("reset data c%0d", k), data_out_a[k], '0);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(tv[i].k, tv[i].inv, tv[i].din, tv[i].exp, tv[i].lat, $sformatf("v%0d", i));
    // backpressure: B held pending on in_valid while A sits in DONE
    in_valid_a[0] = 1'b1; inv_a[0] = 1'b0; data_in_a[0] = A_IN;
    @(posedge clk); #1;
    data_in_a[0] = B_IN;
    wait_out(0, n);
    check("bp latency", 128'(n), 128'd4);
    check("bp data A", data_out_a[0], A_OUT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold data %0d", i), data_out_a[0], A_OUT);
      check($sformatf("bp hold flags %0d", i), flags(0), 128'b101);
    end
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
    check("bp release idle", flags(0), 128'b010);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    check("bp second accepted", flags(0), 128'b100);
    wait_out(0, n);
    check("bp second latency", 128'(n), 128'd4);
    check("bp second data", data_out_a[0], B_OUT);
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
    // flush on the second BUSY cycle with in_valid still high
    in_valid_a[0] = 1'b1; inv_a[0] = 1'b0; data_in_a[0] = A_IN;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_a[0] = 1'b1;
    @(posedge clk); #1;
    flush_a[0] = 1'b0;
    in_valid_a[0] = 1'b0;
    check("flush idle no accept", flags(0), 128'b010);
    check("flush keeps data_out", data_out_a[0], B_OUT);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= out_valid_a[0];
    end
    check("flush no out_valid", 128'(seen), '0);
    run_vec(0, 1'b1, A_OUT, A_IN, 4, "after flush");
    // asynchronous reset mid-BUSY
    in_valid_a[0] = 1'b1; inv_a[0] = 1'b0; data_in_a[0] = B_IN;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async reset flags", flags(0), 128'b010);
    check("async reset data", data_out_a[0], '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(0, 1'b0, '0, '0, 4, "zero block");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Sequential, parametrised MixColumns / InvMixColumns engine for the AES datapath.
- Accepts a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Mode selected per block: forward for encryption, inverse for decryption.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round pipeline; replaces the purely combinational MixColumns stage.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4; any other value is an elaboration error.
- NUM_ITER, 4/COLS_PER_CYCLE, derived constant (localparam); not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  data_in and inv_mode are valid
- in_ready  output  1  block can accept a state
- inv_mode  input  1  0 = MixColumns, 1 = InvMixColumns; sampled on acceptance
- data_in  input  128  state; bits [127:96] = column 0, byte s(0,c) in the MSB of each column
- out_valid  output  1  data_out holds the finished result
- out_ready  input  1  downstream accepts data_out
- data_out  output  128  transformed state, same byte ordering as data_in
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - data_out = 0; internal state register and column index = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch data_in into the working register, latch inv_mode, set column index = 0, go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle, replace COLS_PER_CYCLE columns starting at the current index with their transformed values, then add COLS_PER_CYCLE to the index.
  - After NUM_ITER cycles, go to DONE.
- DONE:
  - out_valid = 1; data_out = working register.
  - data_out is held stable until out_ready.
  - On out_valid && out_ready: clear out_valid and go to IDLE.
- Latency: out_valid rises exactly NUM_ITER cycles after the acceptance edge (1 cycle for COLS_PER_CYCLE = 4, 4 cycles for COLS_PER_CYCLE = 1).
- Throughput: at most one block per NUM_ITER + 2 cycles. No overlap: in_ready is low while BUSY or DONE.
- Arithmetic per column, GF(2^8) with polynomial 0x11B:
  - Forward matrix: 02 03 01 01 (circulant).
  - Inverse matrix: 0E 0B 0D 09 (circulant).
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 0).
  - All products are built from xtime chains; no multipliers, no lookup tables.
- inv_mode changes while BUSY are ignored; the mode latched at acceptance governs the whole block.
- flush:
  - Takes effect at the next edge from any state.
  - Result: state = IDLE, out_valid = 0, index = 0; data_out keeps its last value.
  - flush and in_valid in the same cycle: flush wins, nothing is accepted.
  - flush in DONE with out_ready high: the output handshake does not count as a transfer; the downstream must ignore it.
- in_valid while not ready: no effect; the source must hold its data (standard valid/ready). in_valid is never required to fall.
- out_ready may be held high permanently; DONE then lasts exactly 1 cycle.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded.

Decomposition:
- Package aes_pkg:
  - xtime and gf_mul_const functions (constants 02, 03, 09, 0B, 0D, 0E).
  - FSM state enum (IDLE, BUSY, DONE).
  - Column-slice helpers.
- Sub-module mix_column_word:
  - Purely combinational.
  - Ports: col_in[31:0], inv, col_out[31:0].
  - Instantiated COLS_PER_CYCLE times and fed from the column index.
- Top module: FSM, index counter, working register, handshake.

Test Plan:
- COLS_PER_CYCLE = 1, inv_mode = 0, data_in = d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_valid exactly 4 cycles after acceptance, data_out = 046681e5_e0cb199a_48f8d37a_2806264c.
- COLS_PER_CYCLE = 4, inv_mode = 1, data_in = 046681e5_e0cb199a_48f8d37a_2806264c -> out_valid after 1 cycle, data_out = d4bf5d30_e0b452ae_b84111f1_1e2798e5.
- COLS_PER_CYCLE = 2, inv_mode = 0, data_in = db135345_f20a225c_01010101_c6c6c6c6 -> after 2 cycles, data_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; repeat with inv_mode = 1 on that result -> original input returned.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> data_out stable, in_ready = 0, a second in_valid is not accepted; raise out_ready -> IDLE next cycle, second block accepted.
- flush asserted on the 2nd BUSY cycle (COLS_PER_CYCLE = 1) with in_valid high -> IDLE next edge, no acceptance that cycle, out_valid never rises for the aborted block; the next block produces a correct result.
- rst_n pulsed low asynchronously mid-BUSY -> outputs go to reset values without waiting for a clock edge; all-zero input afterwards -> all-zero output.
